// File: rtl/stripes_sip_tile_pkg.sv
// Shared defaults, FSM state encoding and width/saturation helpers for the Stripes tile.
// Pure declarations: no latency, no flow control.
package stripes_pkg;

    localparam int N_DEF  = 16;
    localparam int TI_DEF = 16;
    localparam int TW_DEF = 16;
    localparam int TN_DEF = 4;
    localparam int PW_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    // Accumulator width: N x N products summed over Ti lanes.
    function automatic int acc_width(input int n, input int ti);
        return 2 * n + $clog2(ti);
    endfunction

    function automatic int sat_hi(input int n);
        return (2 ** (n - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int n);
        return -(2 ** (n - 1));
    endfunction

endpackage

// File: rtl/stripes_sip_tile_if.sv
// Feeder/NBout-facing bundle of the Stripes tile: pass control, bit-plane stream and result.
// Bit stream and result each use valid/ready; start is a single-cycle request.
interface stripes_sip_tile_if #(
    parameter int N  = 16,
    parameter int Ti = 16,
    parameter int Tw = 16,
    parameter int Tn = 4,
    parameter int PW = 5
) ();

    logic                  i_start;
    logic [PW-1:0]         i_precision;
    logic                  i_maxpool;
    logic [N*Ti*Tn-1:0]    i_synapses;
    logic [N*Tn*Tw-1:0]    i_nbout;
    logic                  i_bit_valid;
    logic [Ti*Tw-1:0]      i_act_bits;
    logic                  o_bit_ready;
    logic                  o_busy;
    logic                  o_valid;
    logic                  i_out_ready;
    logic [N*Tn*Tw-1:0]    o_to_bus;

    modport master (
        output i_start, i_precision, i_maxpool, i_synapses, i_nbout,
               i_bit_valid, i_act_bits, i_out_ready,
        input  o_bit_ready, o_busy, o_valid, o_to_bus
    );

    modport slave (
        input  i_start, i_precision, i_maxpool, i_synapses, i_nbout,
               i_bit_valid, i_act_bits, i_out_ready,
        output o_bit_ready, o_busy, o_valid, o_to_bus
    );

endinterface

// File: rtl/stripes_sip_tile_sip.sv
// One serial inner-product unit: AND array, lane sum, shift-accumulate, then saturate/add or max.
// Result registers on the last beat; beat_en gates all state so stalls hold everything.
module stripes_sip
    import stripes_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int TI = TI_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                beat_en,
    input  logic                is_first,
    input  logic                is_last,
    input  logic                maxpool,
    input  logic [N*TI-1:0]     syn,
    input  logic [TI-1:0]       bits,
    input  logic signed [N-1:0] nbout,
    output logic signed [N-1:0] result
);

    localparam int ACC_W = acc_width(N, TI);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'(sat_hi(N));
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W + 1)'(sat_lo(N));

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [N-1:0]     res_q, res_d;
    logic signed [ACC_W-1:0] partial;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W:0]   pre_sat;
    logic signed [N-1:0]     sat_v;
    logic signed [N-1:0]     syn_w;

    always_comb begin
        partial = '0;
        syn_w   = '0;
        for (int i = 0; i < TI; i++) begin
            syn_w = syn[i*N +: N];
            if (bits[i]) begin
                partial = partial + ACC_W'(syn_w);
            end
        end

        acc_next = is_first ? partial : (acc_q <<< 1) + partial;

        // One guard bit so the bias add cannot wrap before clamping.
        pre_sat = maxpool ? (ACC_W + 1)'(acc_next)
                          : (ACC_W + 1)'(acc_next) + (ACC_W + 1)'(nbout);

        if (pre_sat > SAT_MAX) begin
            sat_v = SAT_MAX[N-1:0];
        end else if (pre_sat < SAT_MIN) begin
            sat_v = SAT_MIN[N-1:0];
        end else begin
            sat_v = pre_sat[N-1:0];
        end

        acc_d = acc_q;
        res_d = res_q;
        if (beat_en) begin
            acc_d = acc_next;
            if (is_last) begin
                res_d = (maxpool && (nbout > sat_v)) ? nbout : sat_v;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            res_q <= '0;
        end else begin
            acc_q <= acc_d;
            res_q <= res_d;
        end
    end

    assign result = res_q;

endmodule

// File: rtl/stripes_sip_tile.sv
// Stripes tile: Tn x Tw SIPs sharing a precision-counting FSM, operand latches and result handshake.
// o_valid rises the cycle after the last accepted bit plane; stalls on i_bit_valid=0, holds result until i_out_ready.
module stripes_sip_tile
    import stripes_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int Ti = TI_DEF,
    parameter int Tw = TW_DEF,
    parameter int Tn = TN_DEF,
    parameter int PW = PW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    stripes_sip_tile_if.slave bus
);

    state_e               state_q, state_d;
    logic [PW-1:0]        cnt_q, cnt_d;
    logic                 first_q, first_d;
    logic                 maxpool_q, maxpool_d;
    logic [N*Ti*Tn-1:0]   syn_q, syn_d;
    logic [N*Tn*Tw-1:0]   nbout_q, nbout_d;
    logic [PW-1:0]        prec_eff;
    logic                 beat;
    logic                 last_beat;
    logic [N*Tn*Tw-1:0]   to_bus;

    // Out-of-range precision falls back to full width.
    assign prec_eff  = ((bus.i_precision == '0) || (bus.i_precision > PW'(N)))
                       ? PW'(N) : bus.i_precision;
    assign beat      = (state_q == ST_RUN) && bus.i_bit_valid;
    assign last_beat = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        maxpool_d = maxpool_q;
        syn_d     = syn_q;
        nbout_d   = nbout_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    syn_d     = bus.i_synapses;
                    nbout_d   = bus.i_nbout;
                    maxpool_d = bus.i_maxpool;
                    cnt_d     = prec_eff - 1'b1;
                    first_d   = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (beat) begin
                    cnt_d   = cnt_q - 1'b1;
                    first_d = 1'b0;
                    if (last_beat) begin
                        state_d = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (bus.i_out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            first_q   <= 1'b0;
            maxpool_q <= 1'b0;
            syn_q     <= '0;
            nbout_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
            maxpool_q <= maxpool_d;
            syn_q     <= syn_d;
            nbout_q   <= nbout_d;
        end
    end

    for (genvar n = 0; n < Tn; n++) begin : g_n
        for (genvar w = 0; w < Tw; w++) begin : g_w
            stripes_sip #(
                .N  (N),
                .TI (Ti)
            ) u_sip (
                .clk      (clk),
                .reset    (reset),
                .beat_en  (beat),
                .is_first (first_q),
                .is_last  (last_beat),
                .maxpool  (maxpool_q),
                .syn      (syn_q[n*Ti*N +: Ti*N]),
                .bits     (bus.i_act_bits[w*Ti +: Ti]),
                .nbout    (nbout_q[(n*Tw+w)*N +: N]),
                .result   (to_bus[(n*Tw+w)*N +: N])
            );
        end
    end

    assign bus.o_to_bus    = to_bus;
    assign bus.o_bit_ready = (state_q == ST_RUN);
    assign bus.o_busy      = (state_q != ST_IDLE);
    assign bus.o_valid     = (state_q == ST_OUT);

endmodule

// File: tb/tb_stripes_sip_tile.sv
// Directed bench for stripes_sip_tile: sums, bias, saturation, maxpool, stalls, backpressure, reset.
module tb_stripes_sip_tile;

    localparam int N  = 16;
    localparam int Ti = 16;
    localparam int Tw = 16;
    localparam int Tn = 4;
    localparam int PW = 5;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    stripes_sip_tile_if #(.N(N), .Ti(Ti), .Tw(Tw), .Tn(Tn), .PW(PW)) bif ();

    stripes_sip_tile #(.N(N), .Ti(Ti), .Tw(Tw), .Tn(Tn), .PW(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_bus(input string tag, input logic signed [N-1:0] expw);
        logic [N*Tn*Tw-1:0] expb;
        int idx;
        expb = {(Tn*Tw){expw}};
        idx  = 0;
        total++;
        assert (bif.o_to_bus === expb)
        else begin
            bad++;
            for (int k = Tn*Tw-1; k >= 0; k--) begin
                if (bif.o_to_bus[k*N +: N] !== expb[k*N +: N]) idx = k;
            end
            $error("FAIL %s: word %0d observed=%0h expected=%0h",
                   tag, idx, bif.o_to_bus[idx*N +: N], expw);
        end
    endtask

    task automatic setup(input logic signed [N-1:0] syn, input logic signed [N-1:0] nb,
                         input logic mp);
        bif.i_synapses = {(Ti*Tn){syn}};
        bif.i_nbout    = {(Tn*Tw){nb}};
        bif.i_maxpool  = mp;
    endtask

    // One complete pass with a uniform activation on every lane/window.
    task automatic run_pass(input string tag, input logic [PW-1:0] prec, input int p,
                            input logic [N-1:0] act, input bit gaps, input int hold,
                            input logic signed [N-1:0] expw);
        logic bitv;
        int   g;
        bif.i_out_ready = (hold == 0);
        bif.i_precision = prec;
        bif.i_start     = 1'b1;
        step();
        bif.i_start = 1'b0;
        check({tag, ":busy_run"}, 32'(bif.o_busy), 32'd1);
        check({tag, ":bit_ready"}, 32'(bif.o_bit_ready), 32'd1);
        for (int b = 0; b < p; b++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    bif.i_bit_valid = 1'b0;
                    bif.i_start     = 1'b1;
                    bif.i_act_bits  = {(Ti*Tw){1'b1}};
                    step();
                end
                bif.i_start = 1'b0;
            end
            bitv            = act[p-1-b];
            bif.i_act_bits  = {(Ti*Tw){bitv}};
            bif.i_bit_valid = 1'b1;
            step();
            if (b == p - 2) check({tag, ":valid_early"}, 32'(bif.o_valid), 32'd0);
        end
        bif.i_bit_valid = 1'b0;
        check({tag, ":valid"}, 32'(bif.o_valid), 32'd1);
        check_bus({tag, ":result"}, expw);
        if (hold > 0) begin
            bif.i_start = 1'b1;
            for (int k = 0; k < hold; k++) step();
            check({tag, ":valid_held"}, 32'(bif.o_valid), 32'd1);
            check_bus({tag, ":result_held"}, expw);
            bif.i_start     = 1'b0;
            bif.i_out_ready = 1'b1;
        end
        step();
        bif.i_out_ready = 1'b0;
        check({tag, ":valid_drop"}, 32'(bif.o_valid), 32'd0);
        check({tag, ":idle"}, 32'(bif.o_busy), 32'd0);
        check_bus({tag, ":result_kept"}, expw);
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        reset           = 1'b1;
        bif.i_start     = 1'b0;
        bif.i_precision = '0;
        bif.i_maxpool   = 1'b0;
        bif.i_synapses  = '0;
        bif.i_nbout     = '0;
        bif.i_bit_valid = 1'b0;
        bif.i_act_bits  = '0;
        bif.i_out_ready = 1'b0;
        step();
        step();
        check("rst:valid", 32'(bif.o_valid), 32'd0);
        check("rst:busy", 32'(bif.o_busy), 32'd0);
        check("rst:bit_ready", 32'(bif.o_bit_ready), 32'd0);
        check_bus("rst:bus", 16'sd0);
        reset = 1'b0;
        step();

        // 16 lanes x 1 x 3
        setup(16'sd1, 16'sd0, 1'b0);
        run_pass("sum", 5'd2, 2, 16'd3, 1'b0, 0, 16'sd48);

        // 16 x (-2) x 5 + 10
        setup(-16'sd2, 16'sd10, 1'b0);
        run_pass("bias", 5'd3, 3, 16'd5, 1'b0, 0, -16'sd150);

        setup(16'sd32767, 16'sd0, 1'b0);
        run_pass("sat_hi", 5'd16, 16, 16'hFFFF, 1'b0, 0, 16'sd32767);
        setup(-16'sd32768, 16'sd0, 1'b0);
        run_pass("sat_lo", 5'd16, 16, 16'hFFFF, 1'b0, 0, -16'sd32768);

        setup(16'sd1, 16'sd100, 1'b1);
        run_pass("max_nb", 5'd2, 2, 16'd3, 1'b0, 0, 16'sd100);
        setup(16'sd1, -16'sd7, 1'b1);
        run_pass("max_sum", 5'd2, 2, 16'd3, 1'b0, 0, 16'sd48);

        setup(16'sd1, 16'sd0, 1'b0);
        run_pass("stall", 5'd2, 2, 16'd3, 1'b1, 5, 16'sd48);
        run_pass("prec0", 5'd0, 16, 16'd3, 1'b0, 0, 16'sd48);
        run_pass("prec20", 5'd20, 16, 16'd3, 1'b1, 0, 16'sd48);
        run_pass("prec1", 5'd1, 1, 16'd1, 1'b0, 0, 16'sd16);

        // Abort a 4-beat pass after its first beat.
        setup(16'sd1, 16'sd0, 1'b0);
        bif.i_precision = 5'd4;
        bif.i_start     = 1'b1;
        step();
        bif.i_start     = 1'b0;
        bif.i_act_bits  = {(Ti*Tw){1'b1}};
        bif.i_bit_valid = 1'b1;
        step();
        bif.i_bit_valid = 1'b0;
        reset           = 1'b1;
        step();
        check("midrst:valid", 32'(bif.o_valid), 32'd0);
        check("midrst:busy", 32'(bif.o_busy), 32'd0);
        check("midrst:bit_ready", 32'(bif.o_bit_ready), 32'd0);
        check_bus("midrst:bus", 16'sd0);
        reset = 1'b0;
        step();
        run_pass("fresh", 5'd2, 2, 16'd3, 1'b0, 0, 16'sd48);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
